apb_controller: RTL and testbench
=================================

// Module: apb_controller
// PURPOSE
//  APB-side controller of the AHB-to-APB bridge. Sits directly downstream of ahb_slave and consumes its
//  VALID/HADDR_TEMP/HWRITE_TEMP/HWDATA_TEMP outputs. Converts each accepted AHB transfer into one APB
//  setup+access transaction, decodes the peripheral select, and returns HREADYOUT/HRDATA/HRESP to the
//  AHB side, including the two-cycle AHB ERROR response.
// PARAMETERS
//  NUM_SLAVES  4   APB peripherals, 1..8; width of PSEL
//  SEL_LSB     12  slave index = HADDR_TEMP[SEL_LSB+2:SEL_LSB]
//  TIMEOUT     255 max access cycles waiting for PREADY; 0 disables the timeout
// PORTS
//  HCLK         in   1          bridge clock; all logic on rising edge
//  HRESETn      in   1          synchronous, active-low reset
//  VALID        in   1          ahb_slave has a transfer (HADDR_TEMP/HWRITE_TEMP valid this cycle)
//  HADDR_TEMP   in   32         registered AHB address
//  HWRITE_TEMP  in   1          1 = write, 0 = read
//  HWDATA_TEMP  in   32         registered write data; valid the cycle after VALID
//  PRDATA       in   32         APB read data
//  PREADY       in   1          APB access-phase completion
//  PSLVERR      in   1          APB error; sampled only when PREADY=1 in access phase
//  PSEL         out  NUM_SLAVES one-hot peripheral select
//  PENABLE      out  1          APB access phase
//  PWRITE       out  1          APB direction
//  PADDR        out  32         APB address
//  PWDATA       out  32         APB write data
//  HREADYOUT    out  1          1 = bridge can accept / transfer done
//  HRDATA       out  32         read data returned to AHB
//  HRESP        out  1          1 = ERROR
// BEHAVIOUR
//  Reset (HRESETn=0 at posedge): state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0,
//   HRESP=0, HREADYOUT=1; timeout counter=0. Mid-transfer reset: PSEL/PENABLE drop at that edge, HRDATA
//   keeps reset value 0, no error response is produced.
//  States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2. All outputs registered or decoded from state only.
//  IDLE: HREADYOUT=1. On VALID: PADDR<=HADDR_TEMP, PWRITE<=HWRITE_TEMP, latch slave index.
//   idx>=NUM_SLAVES -> ERR1 (no APB cycle). Else write -> WWAIT, read -> SETUP.
//  WWAIT: HREADYOUT=0, PSEL=0; PWDATA<=HWDATA_TEMP at exit edge; -> SETUP.
//  SETUP: PSEL[idx]=1, PENABLE=0, HREADYOUT=0; -> ACCESS.
//  ACCESS: PSEL[idx]=1, PENABLE=1, HREADYOUT=0; counter increments each cycle with PREADY=0.
//   PREADY=1 & PSLVERR=0: read -> HRDATA<=PRDATA; -> IDLE.
//   PREADY=1 & PSLVERR=1: -> ERR1; HRDATA unchanged.
//   PREADY=0 on TIMEOUT-th access cycle (TIMEOUT!=0) -> ERR1.
//  ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1; -> ERR2.
//  ERR2: HREADYOUT=1, HRESP=1; -> IDLE. HRESP=0 in every other state.
//  Latency, zero-wait APB: read HREADYOUT low 2 cycles; write 3 cycles; decode error 1 cycle low + 1 high.
//  VALID outside IDLE is ignored: upstream is stalled by HREADYOUT=0.
//  PADDR/PWRITE/PWDATA hold their last value between transfers; the counter clears on leaving ACCESS.
// TESTING
//  1 Reset: HRESETn=0 for 2 cycles in mid-ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, HRDATA=0.
//  2 Write 0x0000_1004 / 0x1111_1111, PREADY=1 -> WWAIT, SETUP with PSEL=4'b0010, PENABLE=0,
//    PADDR=0x1004, PWDATA=0x11111111, PWRITE=1, then ACCESS; HREADYOUT low exactly 3 cycles.
//  3 Read 0x0000_2000, PREADY low 3 cycles, PRDATA=0xDEADBEEF -> PSEL=4'b0100, ACCESS lasts 4 cycles,
//    HRDATA=0xDEADBEEF when HREADYOUT returns to 1.
//  4 Read 0x0000_5000 (idx 5) -> PSEL stays 0; HRESP=1 for 2 cycles with HREADYOUT 0 then 1.
//  5 PSLVERR=1 with PREADY=1 -> ERR1/ERR2 response. TIMEOUT=8 with PREADY stuck 0 -> PENABLE high
//    exactly 8 cycles, then ERR1/ERR2.
//  6 16 writes to 0x1004..0x1040 (data +0x11111111 each), then 16 reads back -> every PRDATA returned
//    in order; VALID pulses during busy states cause no extra APB cycle.

Source files
------------

// File: rtl/apb_controller.sv
// APB-side controller of the AHB-to-APB bridge: turns each accepted AHB transfer into one
// APB setup+access pair, decodes PSEL, and returns HREADYOUT/HRDATA/HRESP (incl. two-cycle ERROR).
module apb_controller #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_LSB    = 12,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  VALID,
    input  logic [31:0]           HADDR_TEMP,
    input  logic                  HWRITE_TEMP,
    input  logic [31:0]           HWDATA_TEMP,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TO_EN  = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       hrdata_q, hrdata_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;

    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_err;

    assign sel_idx = HADDR_TEMP[SEL_LSB+IDX_W-1 -: IDX_W];
    assign sel_err = {1'b0, sel_idx} >= (IDX_W+1)'(NUM_SLAVES);

    // Next-state, datapath and output decode; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        hrdata_d    = hrdata_q;
        psel_d      = '0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        hresp_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (VALID) begin
                    paddr_d  = HADDR_TEMP;
                    pwrite_d = HWRITE_TEMP;
                    idx_d    = sel_idx;
                    if (sel_err)          state_d = ERR1;
                    else if (HWRITE_TEMP) state_d = WWAIT;
                    else                  state_d = SETUP;
                end
            end
            WWAIT: begin
                pwdata_d = HWDATA_TEMP;
                state_d  = SETUP;
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    cnt_d = '0;
                    if (PSLVERR) begin
                        state_d = ERR1;
                    end else begin
                        if (!pwrite_q) hrdata_d = PRDATA;
                        state_d = IDLE;
                    end
                end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
                    cnt_d   = '0;
                    state_d = ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Slave index is always in range when SETUP/ACCESS are reached.
        if ((state_d == SETUP) || (state_d == ACCESS)) begin
            psel_d = NUM_SLAVES'(1) << idx_d;
        end
        penable_d   = (state_d == ACCESS);
        hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
        hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRDATA    = hrdata_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: drives AHB-side transfers against a small APB memory slave
// with programmable wait states and error injection.
module tb_apb_controller;

    localparam int unsigned NS = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          VALID = 1'b0;
    logic [31:0]   HADDR_TEMP = '0;
    logic          HWRITE_TEMP = 1'b0;
    logic [31:0]   HWDATA_TEMP = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [NS-1:0] PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;

    apb_controller #(.NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .VALID(VALID), .HADDR_TEMP(HADDR_TEMP),
        .HWRITE_TEMP(HWRITE_TEMP), .HWDATA_TEMP(HWDATA_TEMP), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;

    // APB memory slave: wait_n wait states per access, slverr flags every completion.
    logic [31:0] mem [0:63];
    int          wait_n = 0;
    logic        slverr = 1'b0;
    int          acc_cnt = 0;
    int          setups = 0;

    assign PREADY  = PENABLE && (acc_cnt >= wait_n);
    assign PRDATA  = mem[PADDR[7:2]];
    assign PSLVERR = slverr;

    always @(posedge HCLK) begin
        if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                    acc_cnt <= 0;
        if (PENABLE && PREADY && PWRITE && !PSLVERR) mem[PADDR[7:2]] <= PWDATA;
        if (HRESETn && (|PSEL) && !PENABLE) setups <= setups + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the last transfer.
    int          res_low, res_pen, res_hresp;
    logic [NS-1:0] res_psel;
    logic        res_tmo;
    logic        su_seen;
    logic [NS-1:0] su_psel;
    logic [31:0] su_paddr, su_pwdata;
    logic        su_pwrite;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // One AHB transfer from IDLE back to IDLE; optionally pulses VALID while busy.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input bit pulse);
        int n;
        res_low = 0; res_pen = 0; res_hresp = 0; res_psel = '0; su_seen = 1'b0;
        su_psel = '0; su_paddr = '0; su_pwdata = '0; su_pwrite = 1'b0;
        VALID = 1'b1; HADDR_TEMP = addr; HWRITE_TEMP = wr;
        step();
        VALID = 1'b0; HWDATA_TEMP = wdata;
        n = 0;
        while (!HREADYOUT && n < 64) begin
            res_low++;
            if (PENABLE) res_pen++;
            if (HRESP) res_hresp++;
            res_psel |= PSEL;
            if ((|PSEL) && !PENABLE && !su_seen) begin
                su_seen = 1'b1; su_psel = PSEL; su_paddr = PADDR;
                su_pwdata = PWDATA; su_pwrite = PWRITE;
            end
            if (pulse) begin
                VALID = n[0]; HADDR_TEMP = 32'h0000_3000 + 32'(n); HWRITE_TEMP = ~wr;
            end
            step();
            n++;
        end
        VALID = 1'b0;
        res_tmo = (n >= 64);
        check("xfer_bound", 32'(res_tmo), 32'd0);
        if (HRESP) begin
            res_hresp++;
            step();
        end
    endtask

    int s0;

    initial begin
        // Reset state
        step(); step();
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_hready", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        HRESETn = 1'b1;
        step();

        // Reset in mid-ACCESS
        wait_n = 1000;
        VALID = 1'b1; HADDR_TEMP = 32'h0000_2000; HWRITE_TEMP = 1'b0;
        step();
        VALID = 1'b0;
        step(); step();
        check("mid_penable", 32'(PENABLE), 32'd1);
        HRESETn = 1'b0;
        step();
        check("mid_rst_psel", 32'(PSEL), 32'd0);
        check("mid_rst_penable", 32'(PENABLE), 32'd0);
        check("mid_rst_hready", 32'(HREADYOUT), 32'd1);
        check("mid_rst_hresp", 32'(HRESP), 32'd0);
        check("mid_rst_hrdata", HRDATA, 32'd0);
        step();
        HRESETn = 1'b1;
        wait_n = 0;
        step(); step();
        check("post_rst_hresp", 32'(HRESP), 32'd0);
        check("post_rst_hready", 32'(HREADYOUT), 32'd1);

        // Zero-wait write
        xfer(32'h0000_1004, 1'b1, 32'h1111_1111, 1'b0);
        check("wr_low", 32'(res_low), 32'd3);
        check("wr_pen", 32'(res_pen), 32'd1);
        check("wr_su_psel", 32'(su_psel), 32'b0010);
        check("wr_su_paddr", su_paddr, 32'h0000_1004);
        check("wr_su_pwdata", su_pwdata, 32'h1111_1111);
        check("wr_su_pwrite", 32'(su_pwrite), 32'd1);
        check("wr_hresp", 32'(res_hresp), 32'd0);

        // Read with three wait states
        xfer(32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 1'b0);
        wait_n = 3;
        xfer(32'h0000_2000, 1'b0, 32'd0, 1'b0);
        wait_n = 0;
        check("rd_low", 32'(res_low), 32'd5);
        check("rd_pen", 32'(res_pen), 32'd4);
        check("rd_psel", 32'(res_psel), 32'b0100);
        check("rd_hrdata", HRDATA, 32'hDEAD_BEEF);
        check("rd_pwrite", 32'(PWRITE), 32'd0);

        // Decode error
        s0 = setups;
        xfer(32'h0000_5000, 1'b0, 32'd0, 1'b0);
        check("dec_psel", 32'(res_psel), 32'd0);
        check("dec_pen", 32'(res_pen), 32'd0);
        check("dec_low", 32'(res_low), 32'd1);
        check("dec_hresp", 32'(res_hresp), 32'd2);
        check("dec_setups", 32'(setups - s0), 32'd0);
        check("dec_paddr", PADDR, 32'h0000_5000);
        check("dec_hresp_idle", 32'(HRESP), 32'd0);

        // Slave error
        slverr = 1'b1;
        xfer(32'h0000_1004, 1'b0, 32'd0, 1'b0);
        slverr = 1'b0;
        check("serr_low", 32'(res_low), 32'd3);
        check("serr_pen", 32'(res_pen), 32'd1);
        check("serr_hresp", 32'(res_hresp), 32'd2);
        check("serr_hrdata", HRDATA, 32'hDEAD_BEEF);

        // Timeout with PREADY stuck low
        wait_n = 1000;
        xfer(32'h0000_3000, 1'b0, 32'd0, 1'b0);
        wait_n = 0;
        check("to_pen", 32'(res_pen), 32'd8);
        check("to_low", 32'(res_low), 32'd10);
        check("to_hresp", 32'(res_hresp), 32'd2);
        check("to_psel", 32'(res_psel), 32'b1000);
        check("to_hrdata", HRDATA, 32'hDEAD_BEEF);

        // Burst of writes then reads, VALID pulsing while busy
        s0 = setups;
        for (int i = 0; i < 16; i++) begin
            xfer(32'h0000_1004 + 32'(4 * i), 1'b1, 32'((i + 1) * 32'h1111_1111), 1'b1);
            if (i == 15) check("burst_wr_low", 32'(res_low), 32'd3);
        end
        for (int i = 0; i < 16; i++) begin
            xfer(32'h0000_1004 + 32'(4 * i), 1'b0, 32'd0, 1'b1);
            check($sformatf("burst_rd%0d", i), HRDATA, 32'((i + 1) * 32'h1111_1111));
        end
        check("burst_setups", 32'(setups - s0), 32'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
